// File: rtl/qracc_sram_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port SRAM.
// One downstream transaction in flight at a time; read data is routed back to the owner.
module qracc_sram_arbiter #(
  parameter int numRows = 128,
  parameter int numCols = 32
) (
  input  logic                       clk,
  input  logic                       nrst,

  input  logic                       r0_rq_wr_i,
  input  logic                       r0_rq_valid_i,
  output logic                       r0_rq_ready_o,
  input  logic [numCols-1:0]         r0_wr_data_i,
  input  logic [$clog2(numRows)-1:0] r0_addr_i,
  output logic                       r0_rd_valid_o,
  output logic [numCols-1:0]         r0_rd_data_o,

  input  logic                       r1_rq_wr_i,
  input  logic                       r1_rq_valid_i,
  output logic                       r1_rq_ready_o,
  input  logic [numCols-1:0]         r1_wr_data_i,
  input  logic [$clog2(numRows)-1:0] r1_addr_i,
  output logic                       r1_rd_valid_o,
  output logic [numCols-1:0]         r1_rd_data_o,

  output logic                       sram_rq_wr_o,
  output logic                       sram_rq_valid_o,
  input  logic                       sram_rq_ready_i,
  output logic [numCols-1:0]         sram_wr_data_o,
  output logic [$clog2(numRows)-1:0] sram_addr_o,
  input  logic                       sram_rd_valid_i,
  input  logic [numCols-1:0]         sram_rd_data_i,

  output logic                       busy_o,
  output logic                       owner_o
);

  localparam int AW = $clog2(numRows);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    WAIT_RD = 2'd2
  } state_t;

  state_t               state_r;
  state_t               next_state_s;
  logic                 rr_ptr_r;
  logic                 owner_r;
  logic                 wr_r;
  logic [AW-1:0]        addr_r;
  logic [numCols-1:0]   data_r;
  logic                 r0_rd_valid_r;
  logic                 r1_rd_valid_r;
  logic [numCols-1:0]   r0_rd_data_r;
  logic [numCols-1:0]   r1_rd_data_r;

  logic                 grant_s;
  logic                 grant_idx_s;
  logic                 rd_done_s;
  logic                 sel_wr_s;
  logic [AW-1:0]        sel_addr_s;
  logic [numCols-1:0]   sel_data_s;

  // Next-state, grant selection and read-completion decode.
  always_comb begin
    next_state_s = state_r;
    grant_s      = 1'b0;
    grant_idx_s  = 1'b0;
    rd_done_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (r0_rq_valid_i && r1_rq_valid_i) begin
          grant_s     = 1'b1;
          grant_idx_s = rr_ptr_r;
        end else if (r0_rq_valid_i) begin
          grant_s     = 1'b1;
          grant_idx_s = 1'b0;
        end else if (r1_rq_valid_i) begin
          grant_s     = 1'b1;
          grant_idx_s = 1'b1;
        end else begin
          grant_s     = 1'b0;
          grant_idx_s = 1'b0;
        end
        if (grant_s) begin
          next_state_s = REQ;
        end else begin
          next_state_s = IDLE;
        end
      end
      REQ: begin
        if (sram_rq_ready_i) begin
          next_state_s = wr_r ? IDLE : WAIT_RD;
        end else begin
          next_state_s = REQ;
        end
      end
      WAIT_RD: begin
        if (sram_rd_valid_i) begin
          rd_done_s    = 1'b1;
          next_state_s = IDLE;
        end else begin
          next_state_s = WAIT_RD;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // Payload of the granted requester.
  always_comb begin
    sel_wr_s   = 1'b0;
    sel_addr_s = {AW{1'b0}};
    sel_data_s = {numCols{1'b0}};
    if (grant_idx_s) begin
      sel_wr_s   = r1_rq_wr_i;
      sel_addr_s = r1_addr_i;
      sel_data_s = r1_wr_data_i;
    end else begin
      sel_wr_s   = r0_rq_wr_i;
      sel_addr_s = r0_addr_i;
      sel_data_s = r0_wr_data_i;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Captured request payload, owner and round-robin pointer, updated on grant.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_r     <= 1'b0;
      addr_r   <= {AW{1'b0}};
      data_r   <= {numCols{1'b0}};
      owner_r  <= 1'b0;
      rr_ptr_r <= 1'b0;
    end else if (grant_s) begin
      wr_r     <= sel_wr_s;
      addr_r   <= sel_addr_s;
      data_r   <= sel_data_s;
      owner_r  <= grant_idx_s;
      rr_ptr_r <= ~grant_idx_s;
    end
  end

  // Read return: one-cycle pulse to the owner, data held until the next return.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r0_rd_valid_r <= 1'b0;
      r1_rd_valid_r <= 1'b0;
      r0_rd_data_r  <= {numCols{1'b0}};
      r1_rd_data_r  <= {numCols{1'b0}};
    end else begin
      r0_rd_valid_r <= rd_done_s && !owner_r;
      r1_rd_valid_r <= rd_done_s &&  owner_r;
      if (rd_done_s && !owner_r) begin
        r0_rd_data_r <= sram_rd_data_i;
      end
      if (rd_done_s && owner_r) begin
        r1_rd_data_r <= sram_rd_data_i;
      end
    end
  end

  // Ready must be combinational so a lone requester is accepted in the same IDLE cycle.
  assign r0_rq_ready_o   = grant_s && !grant_idx_s;
  assign r1_rq_ready_o   = grant_s &&  grant_idx_s;

  assign sram_rq_valid_o = (state_r == REQ);
  assign sram_rq_wr_o    = wr_r;
  assign sram_addr_o     = addr_r;
  assign sram_wr_data_o  = data_r;

  assign r0_rd_valid_o   = r0_rd_valid_r;
  assign r1_rd_valid_o   = r1_rd_valid_r;
  assign r0_rd_data_o    = r0_rd_data_r;
  assign r1_rd_data_o    = r1_rd_data_r;

  assign busy_o          = (state_r != IDLE);
  assign owner_o         = owner_r;

endmodule

// File: tb/tb_qracc_sram_arbiter.sv
// Scoreboard bench: stimulus queues expected downstream requests and read returns,
// a negedge monitor pops and compares them when the DUT presents them.
module tb_qracc_sram_arbiter;

  logic        clk;
  logic        nrst;
  logic        r0_rq_wr, r0_rq_valid, r0_rq_ready, r0_rd_valid;
  logic [31:0] r0_wr_data, r0_rd_data;
  logic [6:0]  r0_addr;
  logic        r1_rq_wr, r1_rq_valid, r1_rq_ready, r1_rd_valid;
  logic [31:0] r1_wr_data, r1_rd_data;
  logic [6:0]  r1_addr;
  logic        sram_rq_wr, sram_rq_valid, sram_rq_ready, sram_rd_valid;
  logic [31:0] sram_wr_data, sram_rd_data;
  logic [6:0]  sram_addr;
  logic        busy, owner;

  typedef struct packed {
    logic        wr;
    logic [6:0]  addr;
    logic [31:0] data;
    logic        owner;
  } dn_t;

  typedef struct packed {
    logic        idx;
    logic [31:0] data;
  } rd_t;

  dn_t exp_dn[$];
  rd_t exp_rd[$];
  int  n_checks = 0;
  int  n_fail   = 0;

  qracc_sram_arbiter #(.numRows(128), .numCols(32)) dut (
    .clk(clk), .nrst(nrst),
    .r0_rq_wr_i(r0_rq_wr), .r0_rq_valid_i(r0_rq_valid), .r0_rq_ready_o(r0_rq_ready),
    .r0_wr_data_i(r0_wr_data), .r0_addr_i(r0_addr),
    .r0_rd_valid_o(r0_rd_valid), .r0_rd_data_o(r0_rd_data),
    .r1_rq_wr_i(r1_rq_wr), .r1_rq_valid_i(r1_rq_valid), .r1_rq_ready_o(r1_rq_ready),
    .r1_wr_data_i(r1_wr_data), .r1_addr_i(r1_addr),
    .r1_rd_valid_o(r1_rd_valid), .r1_rd_data_o(r1_rd_data),
    .sram_rq_wr_o(sram_rq_wr), .sram_rq_valid_o(sram_rq_valid), .sram_rq_ready_i(sram_rq_ready),
    .sram_wr_data_o(sram_wr_data), .sram_addr_o(sram_addr),
    .sram_rd_valid_i(sram_rd_valid), .sram_rd_data_i(sram_rd_data),
    .busy_o(busy), .owner_o(owner)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a downstream request or read return.
  always @(negedge clk) begin
    if (nrst) begin
      chk("ready_exclusive", 32'((r0_rq_ready && r1_rq_ready) || (busy && (r0_rq_ready || r1_rq_ready))), 32'd0);
      if (sram_rq_valid && sram_rq_ready) begin
        if (exp_dn.size() == 0) begin
          chk("unexpected_dn_request", 32'd1, 32'd0);
        end else begin
          dn_t e;
          e = exp_dn.pop_front();
          chk("dn_wr",    32'(sram_rq_wr),  32'(e.wr));
          chk("dn_addr",  32'(sram_addr),   32'(e.addr));
          chk("dn_data",  sram_wr_data,     e.data);
          chk("dn_owner", 32'(owner),       32'(e.owner));
        end
      end
      if (r0_rd_valid || r1_rd_valid) begin
        chk("rd_one_hot", 32'(r0_rd_valid && r1_rd_valid), 32'd0);
        if (exp_rd.size() == 0) begin
          chk("unexpected_rd_pulse", 32'd1, 32'd0);
        end else begin
          rd_t r;
          r = exp_rd.pop_front();
          chk("rd_target", 32'(r1_rd_valid), 32'(r.idx));
          chk("rd_data",   r.idx ? r1_rd_data : r0_rd_data, r.data);
        end
      end
    end
  end

  initial begin
    nrst = 1'b0;
    r0_rq_wr = 1'b0; r0_rq_valid = 1'b0; r0_wr_data = 32'h0; r0_addr = 7'd0;
    r1_rq_wr = 1'b0; r1_rq_valid = 1'b0; r1_wr_data = 32'h0; r1_addr = 7'd0;
    sram_rq_ready = 1'b0; sram_rd_valid = 1'b0; sram_rd_data = 32'h0;

    // Reset state
    sample();
    chk("rst_busy",      32'(busy),          32'd0);
    chk("rst_owner",     32'(owner),         32'd0);
    chk("rst_dn_valid",  32'(sram_rq_valid), 32'd0);
    chk("rst_dn_addr",   32'(sram_addr),     32'd0);
    chk("rst_dn_data",   sram_wr_data,       32'd0);
    chk("rst_r0_rdata",  r0_rd_data,         32'd0);
    step();
    nrst = 1'b1;

    // T1: r0 write addr 5, downstream always ready
    step();
    r0_rq_valid = 1'b1; r0_rq_wr = 1'b1; r0_addr = 7'd5; r0_wr_data = 32'hA5A5A5A5;
    sram_rq_ready = 1'b1;
    exp_dn.push_back('{wr: 1'b1, addr: 7'd5, data: 32'hA5A5A5A5, owner: 1'b0});
    sample();
    chk("t1_r0_ready",       32'(r0_rq_ready),   32'd1);
    chk("t1_r1_ready",       32'(r1_rq_ready),   32'd0);
    chk("t1_dn_valid_early", 32'(sram_rq_valid), 32'd0);
    step();
    r0_rq_valid = 1'b0;
    sample();
    chk("t1_dn_valid", 32'(sram_rq_valid), 32'd1);
    step();
    sample();
    chk("t1_back_idle", 32'(busy), 32'd0);

    // T2: both requesters valid right after reset -> r0, r1, r0, r1
    nrst = 1'b0;
    step();
    nrst = 1'b1;
    r0_rq_valid = 1'b1; r0_rq_wr = 1'b1; r0_addr = 7'd1; r0_wr_data = 32'h11111111;
    r1_rq_valid = 1'b1; r1_rq_wr = 1'b1; r1_addr = 7'd2; r1_wr_data = 32'h22222222;
    for (int k = 0; k < 2; k++) begin
      exp_dn.push_back('{wr: 1'b1, addr: 7'd1, data: 32'h11111111, owner: 1'b0});
      exp_dn.push_back('{wr: 1'b1, addr: 7'd2, data: 32'h22222222, owner: 1'b1});
    end
    for (int i = 0; i < 8; i++) begin
      sample();
      if (i % 2 == 0) begin
        chk("t2_grant_r0", 32'(r0_rq_ready), 32'((i % 4) == 0));
        chk("t2_grant_r1", 32'(r1_rq_ready), 32'((i % 4) == 2));
      end
      step();
    end
    r0_rq_valid = 1'b0; r1_rq_valid = 1'b0;

    // T3: r1 read addr 9, data returns 3 cycles after acceptance
    r1_rq_valid = 1'b1; r1_rq_wr = 1'b0; r1_addr = 7'd9; r1_wr_data = 32'h0;
    exp_dn.push_back('{wr: 1'b0, addr: 7'd9, data: 32'h0, owner: 1'b1});
    sample();
    chk("t3_r1_ready", 32'(r1_rq_ready), 32'd1);
    step();
    r1_rq_valid = 1'b0;
    step();
    step();
    step();
    sram_rd_valid = 1'b1; sram_rd_data = 32'h12345678;
    exp_rd.push_back('{idx: 1'b1, data: 32'h12345678});
    sample();
    chk("t3_no_early_pulse", 32'(r1_rd_valid), 32'd0);
    step();
    sram_rd_valid = 1'b0; sram_rd_data = 32'h0;
    sample();
    chk("t3_r1_pulse", 32'(r1_rd_valid), 32'd1);
    chk("t3_r1_data",  r1_rd_data,       32'h12345678);
    chk("t3_r0_quiet", 32'(r0_rd_valid), 32'd0);
    chk("t3_idle",     32'(busy),        32'd0);
    step();
    sample();
    chk("t3_pulse_ends", 32'(r1_rd_valid), 32'd0);
    chk("t3_data_held",  r1_rd_data,       32'h12345678);

    // T4: downstream stalls for 4 cycles in REQ
    step();
    r0_rq_valid = 1'b1; r0_rq_wr = 1'b1; r0_addr = 7'h33; r0_wr_data = 32'hDEADBEEF;
    sram_rq_ready = 1'b0;
    exp_dn.push_back('{wr: 1'b1, addr: 7'h33, data: 32'hDEADBEEF, owner: 1'b0});
    sample();
    chk("t4_r0_ready", 32'(r0_rq_ready), 32'd1);
    step();
    r0_rq_valid = 1'b0;
    r1_rq_valid = 1'b1; r1_rq_wr = 1'b0; r1_addr = 7'd7;
    for (int i = 0; i < 4; i++) begin
      sample();
      chk("t4_stall_valid", 32'(sram_rq_valid), 32'd1);
      chk("t4_stall_addr",  32'(sram_addr),     32'h33);
      chk("t4_stall_data",  sram_wr_data,       32'hDEADBEEF);
      chk("t4_stall_r0rdy", 32'(r0_rq_ready),   32'd0);
      chk("t4_stall_r1rdy", 32'(r1_rq_ready),   32'd0);
      step();
    end
    sram_rq_ready = 1'b1;
    r1_rq_valid = 1'b0;
    sample();
    step();
    sram_rq_ready = 1'b0;
    sample();
    chk("t4_back_idle", 32'(busy), 32'd0);

    // T5: reset while waiting for read data; late data must not be delivered
    step();
    r0_rq_valid = 1'b1; r0_rq_wr = 1'b0; r0_addr = 7'd3; r0_wr_data = 32'h0;
    sram_rq_ready = 1'b1;
    exp_dn.push_back('{wr: 1'b0, addr: 7'd3, data: 32'h0, owner: 1'b0});
    sample();
    step();
    r0_rq_valid = 1'b0;
    sample();
    step();
    sram_rq_ready = 1'b0;
    sample();
    chk("t5_wait_rd_busy", 32'(busy), 32'd1);
    nrst = 1'b0;
    #1;
    chk("t5_async_reset_busy", 32'(busy), 32'd0);
    step();
    nrst = 1'b1;
    sram_rd_valid = 1'b1; sram_rd_data = 32'hBAD0BAD0;
    sample();
    chk("t5_idle_after_rst", 32'(busy), 32'd0);
    step();
    sram_rd_valid = 1'b0; sram_rd_data = 32'h0;
    sample();
    chk("t5_no_r0_pulse",   32'(r0_rd_valid), 32'd0);
    chk("t5_no_r1_pulse",   32'(r1_rd_valid), 32'd0);
    chk("t5_busy",          32'(busy),        32'd0);
    chk("t5_r1_data_clear", r1_rd_data,       32'd0);
    chk("t5_owner_clear",   32'(owner),       32'd0);
    chk("t5_addr_clear",    32'(sram_addr),   32'd0);

    // T6: spurious read data and ready while IDLE
    step();
    sram_rd_valid = 1'b1; sram_rd_data = 32'hFFFF0000; sram_rq_ready = 1'b1;
    sample();
    chk("t6_idle", 32'(busy), 32'd0);
    step();
    sram_rd_valid = 1'b0; sram_rq_ready = 1'b0;
    sample();
    chk("t6_no_r0_pulse", 32'(r0_rd_valid),   32'd0);
    chk("t6_no_r1_pulse", 32'(r1_rd_valid),   32'd0);
    chk("t6_still_idle",  32'(busy),          32'd0);
    chk("t6_dn_quiet",    32'(sram_rq_valid), 32'd0);
    chk("t6_r0_data",     r0_rd_data,         32'd0);

    step();
    step();
    sample();
    chk("dn_queue_drained", 32'(exp_dn.size()), 32'd0);
    chk("rd_queue_drained", 32'(exp_rd.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
